// File: rtl/calc_pkg.sv
// Shared key codes, operator/error encodings, FSM states and decimal scale helpers
// for the fixed-point calculator core.
package calc_pkg;

  localparam logic [4:0] KEY_DOT   = 5'd10;
  localparam logic [4:0] KEY_NEG   = 5'd11;
  localparam logic [4:0] KEY_ADD   = 5'd12;
  localparam logic [4:0] KEY_SUB   = 5'd13;
  localparam logic [4:0] KEY_MUL   = 5'd14;
  localparam logic [4:0] KEY_DIV   = 5'd15;
  localparam logic [4:0] KEY_EQUAL = 5'd16;
  localparam logic [4:0] KEY_CLEAR = 5'd17;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DIV0 = 2'd1,
    ERR_OVF  = 2'd2
  } err_t;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_OP_SET  = 3'd1,
    ST_ENTRY_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // 10^n for n in 0..4, fixed loop bound so it also maps to plain logic
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 32'd1;
    for (int unsigned i = 0; i < 32'd4; i++) begin
      if (i < n) p = p * 32'd10;
    end
    return p;
  endfunction

  function automatic int unsigned scale_of(input int unsigned frac_digits);
    return pow10(frac_digits);
  endfunction

  function automatic op_t key_to_op(input logic [4:0] code);
    case (code)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_seq_divider.sv
// Unsigned restoring divider: 2*WIDTH-bit numerator by WIDTH-bit divisor,
// one quotient bit per cycle, done pulses for one cycle after the last bit.
module calc_seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   numerator,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   quotient
);

  localparam int unsigned NW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(NW + 1);

  logic [WIDTH-1:0] r_rem;
  logic [NW-1:0]    r_quot;
  logic [WIDTH-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  // Shift the next numerator bit into the partial remainder and try a subtract
  always_comb begin
    w_rem_sh   = {r_rem, r_quot[NW-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_den});
    w_rem_next = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_den}) : WIDTH'(w_rem_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= '0;
        r_quot <= numerator;
        r_den  <= divisor;
        r_cnt  <= CNT_W'(NW);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[NW-2:0], w_ge};
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quot;

endmodule

// File: rtl/fixed_point_calc_core.sv
// Decimal fixed-point calculator engine: key handshake, entry editing, chained
// operations with repeat-equals, and error handling. Values are scaled by 10^FRAC_DIGITS.
module fixed_point_calc_core
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAC_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [4:0]              key_code,
  output logic                    key_ready,
  output logic signed [WIDTH-1:0] display_value,
  output logic signed [WIDTH-1:0] result,
  output logic [2:0]              op_pending,
  output logic [1:0]              err
);

  localparam int unsigned    CW      = 2 * WIDTH;
  localparam int unsigned    SCALE   = scale_of(FRAC_DIGITS);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0]  MAX_CW  = CW'(MAX_POS);

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_entry;
  logic                    r_dot;
  logic [2:0]              r_fcnt;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic signed [WIDTH-1:0] r_result;
  logic signed [WIDTH-1:0] r_display;
  op_t                     r_op;
  op_t                     r_next_op;
  logic                    r_chain;
  err_t                    r_err;
  logic                    r_ready;
  logic                    r_exec_first;

  logic                    w_accept;
  logic                    w_is_digit;
  logic                    w_is_op;
  logic                    w_ent_neg;
  logic [WIDTH-1:0]        w_ent_mag;
  logic [CW-1:0]           w_digit;
  logic [CW-1:0]           w_new_mag;
  logic                    w_dig_ok;
  logic signed [WIDTH-1:0] w_dig_entry;

  logic [WIDTH-1:0]        w_a_mag;
  logic [WIDTH-1:0]        w_b_mag;
  logic                    w_res_neg;
  logic                    w_is_muldiv;
  logic                    w_div0;
  logic [CW-1:0]           w_num;
  logic [WIDTH-1:0]        w_den;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_sum_mag;
  logic                    w_div_start;
  logic                    w_div_busy;
  logic                    w_div_done;
  logic [CW-1:0]           w_quot;
  logic signed [WIDTH-1:0] w_wb_val;
  logic                    w_wb_ovf;
  logic                    w_wb_fire;

  assign w_accept   = key_valid && r_ready;
  assign w_is_digit = (key_code <= 5'd9);
  assign w_is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);

  // Digit editing works on the entry magnitude, then restores its sign
  always_comb begin
    w_ent_neg = r_entry[WIDTH-1];
    w_ent_mag = w_ent_neg ? WIDTH'(-r_entry) : WIDTH'(r_entry);
    w_digit   = CW'(key_code[3:0]);
    w_new_mag = CW'(w_ent_mag);
    w_dig_ok  = 1'b0;
    if (!r_dot) begin
      w_new_mag = CW'(w_ent_mag) * CW'(10) + w_digit * CW'(SCALE);
      w_dig_ok  = (w_new_mag <= MAX_CW);
    end else if (32'(r_fcnt) < FRAC_DIGITS) begin
      w_new_mag = CW'(w_ent_mag)
                + w_digit * CW'(pow10(FRAC_DIGITS - 32'd1 - 32'(r_fcnt)));
      w_dig_ok  = (w_new_mag <= MAX_CW);
    end
    w_dig_entry = w_ent_neg ? -WIDTH'(w_new_mag) : WIDTH'(w_new_mag);
  end

  // Operand magnitudes, add/sub path and writeback selection
  always_comb begin
    w_a_mag     = r_a[WIDTH-1] ? WIDTH'(-r_a) : WIDTH'(r_a);
    w_b_mag     = r_b[WIDTH-1] ? WIDTH'(-r_b) : WIDTH'(r_b);
    w_res_neg   = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    w_is_muldiv = (r_op == OP_MUL) || (r_op == OP_DIV);
    w_div0      = (r_op == OP_DIV) && (r_b == '0);
    w_num       = (r_op == OP_MUL) ? CW'(w_a_mag) * CW'(w_b_mag)
                                   : CW'(w_a_mag) * CW'(SCALE);
    w_den       = (r_op == OP_MUL) ? WIDTH'(SCALE) : w_b_mag;
    w_sum       = (r_op == OP_SUB) ? {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b}
                                   : {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
    w_sum_mag   = w_sum[WIDTH] ? -w_sum : w_sum;
    if (w_is_muldiv) begin
      w_wb_val = w_res_neg ? -WIDTH'(w_quot) : WIDTH'(w_quot);
      w_wb_ovf = (w_quot > MAX_CW);
    end else begin
      w_wb_val = w_sum[WIDTH-1:0];
      w_wb_ovf = (w_sum_mag > {1'b0, MAX_POS});
    end
    w_div_start = (r_state == ST_EXEC) && r_exec_first && w_is_muldiv
                  && !w_div0 && !w_div_busy;
    w_wb_fire   = (r_state == ST_EXEC)
                  && ((r_exec_first && !w_is_muldiv) || w_div_done);
  end

  calc_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .numerator (w_num),
    .divisor   (w_den),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ENTRY_A;
      r_entry      <= '0;
      r_dot        <= 1'b0;
      r_fcnt       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_display    <= '0;
      r_op         <= OP_NONE;
      r_next_op    <= OP_NONE;
      r_chain      <= 1'b0;
      r_err        <= ERR_NONE;
      r_ready      <= 1'b1;
      r_exec_first <= 1'b0;
    end else if (w_accept && (key_code == KEY_CLEAR)) begin
      r_state   <= ST_ENTRY_A;
      r_entry   <= '0;
      r_dot     <= 1'b0;
      r_fcnt    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_display <= '0;
      r_op      <= OP_NONE;
      r_next_op <= OP_NONE;
      r_chain   <= 1'b0;
      r_err     <= ERR_NONE;
    end else begin
      case (r_state)
        ST_ENTRY_A, ST_ENTRY_B: begin
          if (w_accept) begin
            if (w_is_digit) begin
              if (w_dig_ok) begin
                r_entry   <= w_dig_entry;
                r_display <= w_dig_entry;
                if (r_dot) r_fcnt <= r_fcnt + 3'd1;
              end
            end else if (key_code == KEY_DOT) begin
              r_dot <= 1'b1;
            end else if (key_code == KEY_NEG) begin
              r_entry   <= -r_entry;
              r_display <= -r_entry;
            end else if (w_is_op || (key_code == KEY_EQUAL)) begin
              r_entry <= '0;
              r_dot   <= 1'b0;
              r_fcnt  <= '0;
              if (r_state == ST_ENTRY_A) begin
                r_a       <= r_entry;
                r_display <= r_entry;
                if (w_is_op) begin
                  r_op    <= key_to_op(key_code);
                  r_state <= ST_OP_SET;
                end else begin
                  r_result <= r_entry;
                  r_state  <= ST_RESULT;
                end
              end else begin
                r_b          <= r_entry;
                r_chain      <= w_is_op;
                r_next_op    <= key_to_op(key_code);
                r_state      <= ST_EXEC;
                r_ready      <= 1'b0;
                r_exec_first <= 1'b1;
              end
            end
          end
        end

        ST_OP_SET: begin
          if (w_accept) begin
            if (w_is_op) begin
              r_op <= key_to_op(key_code);
            end else if (w_is_digit) begin
              if (w_dig_ok) begin
                r_entry   <= w_dig_entry;
                r_display <= w_dig_entry;
                r_state   <= ST_ENTRY_B;
              end
            end else if (key_code == KEY_DOT) begin
              r_dot     <= 1'b1;
              r_display <= '0;
              r_state   <= ST_ENTRY_B;
            end else if (key_code == KEY_EQUAL) begin
              r_b          <= r_a;
              r_chain      <= 1'b0;
              r_state      <= ST_EXEC;
              r_ready      <= 1'b0;
              r_exec_first <= 1'b1;
            end
          end
        end

        ST_EXEC: begin
          r_exec_first <= 1'b0;
          if (r_exec_first && w_div0) begin
            r_err     <= ERR_DIV0;
            r_display <= '0;
            r_chain   <= 1'b0;
            r_state   <= ST_ERROR;
            r_ready   <= 1'b1;
          end else if (w_wb_fire) begin
            r_ready <= 1'b1;
            r_chain <= 1'b0;
            if (w_wb_ovf) begin
              r_err     <= ERR_OVF;
              r_display <= '0;
              r_state   <= ST_ERROR;
            end else begin
              r_result  <= w_wb_val;
              r_display <= w_wb_val;
              if (r_chain) begin
                r_a     <= w_wb_val;
                r_op    <= r_next_op;
                r_state <= ST_OP_SET;
              end else begin
                r_state <= ST_RESULT;
              end
            end
          end
        end

        ST_RESULT: begin
          if (w_accept) begin
            if (w_is_digit) begin
              if (w_dig_ok) begin
                r_entry   <= w_dig_entry;
                r_display <= w_dig_entry;
                r_state   <= ST_ENTRY_A;
              end
            end else if (key_code == KEY_DOT) begin
              r_dot     <= 1'b1;
              r_display <= '0;
              r_state   <= ST_ENTRY_A;
            end else if (key_code == KEY_NEG) begin
              r_result  <= -r_result;
              r_display <= -r_result;
            end else if (w_is_op) begin
              r_a       <= r_result;
              r_op      <= key_to_op(key_code);
              r_display <= r_result;
              r_state   <= ST_OP_SET;
            end else if ((key_code == KEY_EQUAL) && (r_op != OP_NONE)) begin
              // Repeat-equals: last op and last B applied to the current result
              r_a          <= r_result;
              r_chain      <= 1'b0;
              r_state      <= ST_EXEC;
              r_ready      <= 1'b0;
              r_exec_first <= 1'b1;
            end
          end
        end

        ST_ERROR: begin
          r_display <= '0;
        end

        default: begin
          r_state <= ST_ENTRY_A;
        end
      endcase
    end
  end

  assign key_ready     = r_ready;
  assign display_value = r_display;
  assign result        = r_result;
  assign op_pending    = r_op;
  assign err           = r_err;

endmodule

// File: tb/tb_fixed_point_calc_core.sv
// Directed bench for fixed_point_calc_core (WIDTH=16, FRAC_DIGITS=2) with
// hand-computed expected values.
module tb_fixed_point_calc_core;

  localparam logic [4:0] K_DOT   = 5'd10;
  localparam logic [4:0] K_NEG   = 5'd11;
  localparam logic [4:0] K_ADD   = 5'd12;
  localparam logic [4:0] K_SUB   = 5'd13;
  localparam logic [4:0] K_MUL   = 5'd14;
  localparam logic [4:0] K_DIV   = 5'd15;
  localparam logic [4:0] K_EQUAL = 5'd16;
  localparam logic [4:0] K_CLEAR = 5'd17;

  logic               clk;
  logic               rst_n;
  logic               key_valid;
  logic [4:0]         key_code;
  logic               key_ready;
  logic signed [15:0] display_value;
  logic signed [15:0] result;
  logic [2:0]         op_pending;
  logic [1:0]         err;

  int n_checks = 0;
  int n_errors = 0;
  int last_low = 0;

  fixed_point_calc_core #(.WIDTH(16), .FRAC_DIGITS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ready     (key_ready),
    .display_value (display_value),
    .result        (result),
    .op_pending    (op_pending),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one key, then count the cycles key_ready stays low afterwards
  task automatic press(input logic [4:0] code);
    int guard;
    guard = 0;
    while (!key_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!key_ready) check("ready_before_key", 32'(key_ready), 1);
    key_code  = code;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    last_low  = 0;
    while (!key_ready && last_low < 100) begin
      @(posedge clk); #1;
      last_low++;
    end
    if (!key_ready) check("ready_after_key", 32'(key_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(key_ready), 1);
    check("rst_display", display_value, 0);
    check("rst_result", result, 0);
    check("rst_op", 32'(op_pending), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5.25 + 3 = 8.25
    press(5'd5); press(K_DOT); press(5'd2); press(5'd5);
    check("t1_entry", display_value, 525);
    press(K_ADD);
    check("t1_a_shown", display_value, 525);
    check("t1_op", 32'(op_pending), 1);
    press(5'd3);
    check("t1_b", display_value, 300);
    press(K_EQUAL);
    check("t1_latency", last_low, 1);
    check("t1_result", result, 825);
    check("t1_display", display_value, 825);

    // Chaining: 5 - 3 + 2 = 4
    press(K_CLEAR);
    press(5'd5); press(K_SUB); press(5'd3); press(K_ADD);
    check("t2_chain_lat", last_low, 1);
    check("t2_chain_disp", display_value, 200);
    check("t2_chain_res", result, 200);
    check("t2_chain_op", 32'(op_pending), 1);
    press(5'd2); press(K_EQUAL);
    check("t2_result", result, 400);

    // Sequential divide / multiply and repeat-equals
    press(K_CLEAR);
    press(5'd6); press(K_DIV); press(5'd3); press(K_EQUAL);
    check("t3_div_lat", last_low, 34);
    check("t3_div", display_value, 200);
    press(K_MUL); press(5'd8); press(K_EQUAL);
    check("t3_mul_lat", last_low, 34);
    check("t3_mul", result, 1600);
    press(K_EQUAL);
    check("t3_repeat", result, 12800);
    check("t3_repeat_disp", display_value, 12800);

    // Divide by zero, error lock-out and clear
    press(K_CLEAR);
    press(5'd7); press(K_DIV); press(5'd0); press(K_EQUAL);
    check("t4_div0_lat", last_low, 1);
    check("t4_err", 32'(err), 1);
    check("t4_display", display_value, 0);
    press(5'd5);
    check("t4_ignored_disp", display_value, 0);
    check("t4_ignored_err", 32'(err), 1);
    press(K_CLEAR);
    check("t4_clr_err", 32'(err), 0);
    check("t4_clr_disp", display_value, 0);
    check("t4_clr_op", 32'(op_pending), 0);

    // Entry range limit, then overflow leaves result untouched
    press(5'd1); press(K_ADD); press(5'd1); press(K_EQUAL);
    check("t5_pre", result, 200);
    press(5'd3); press(5'd2); press(5'd7); press(5'd8);
    check("t5_range", display_value, 32700);
    press(K_MUL); press(5'd2); press(K_EQUAL);
    check("t5_ovf_err", 32'(err), 2);
    check("t5_ovf_res", result, 200);
    check("t5_ovf_disp", display_value, 0);
    press(K_CLEAR);
    press(5'd2); press(K_NEG);
    check("t5_neg", display_value, -200);
    press(K_MUL); press(5'd1); press(K_DOT); press(5'd5); press(K_EQUAL);
    check("t5_neg_mul", result, -300);

    // Second DOT and surplus fraction digits ignored; negative difference
    press(K_CLEAR);
    press(5'd1); press(K_DOT); press(5'd2); press(K_DOT); press(5'd3); press(5'd4);
    check("t7_frac", display_value, 123);
    press(K_CLEAR);
    press(5'd3); press(K_SUB); press(5'd5); press(K_EQUAL);
    check("t7_neg_sub", result, -200);

    // Reset in the middle of a multiply
    press(K_CLEAR);
    press(5'd4); press(K_MUL); press(5'd2);
    key_code  = K_EQUAL;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("t6_busy", 32'(key_ready), 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(key_ready), 1);
    check("t6_rst_disp", display_value, 0);
    check("t6_rst_res", result, 0);
    check("t6_rst_op", 32'(op_pending), 0);
    check("t6_rst_err", 32'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_release_ready", 32'(key_ready), 1);
    press(5'd3); press(K_ADD); press(5'd4); press(K_EQUAL);
    check("t6_after", result, 700);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
